// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial sequence detector.
//   state_e      : controller states (IDLE, RUN)
//   DEF_*        : default parameter values for the detector path
//   clamp_len()  : maps a raw cfg_len onto the legal range 1..max_len
package seq_detect_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_PAT_W    = 8;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_MAX_BITS = 100;

    // A zero length means "one bit"; anything beyond the window size is
    // truncated to the full window.
    function automatic logic [3:0] clamp_len(input logic [3:0] len,
                                             input int unsigned max_len);
        logic [3:0] res;
        if (len == 4'd0) begin
            res = 4'd1;
        end else if ({28'd0, len} > max_len) begin
            res = max_len[3:0];
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_window.sv
// Shift-register window with fill tracking and a length-masked compare.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : empty the window and fill counter (start of a run)
//   shift        : accept bit_in this cycle
//   bit_in       : incoming serial bit
//   overlap      : 1 = keep fill after a hit, 0 = restart filling after a hit
//   len          : effective pattern length (already clamped to 1..PAT_W)
//   pattern      : reference pattern, bit [len-1] is the oldest bit
//   hit          : combinational, the bit being shifted completes a match
module seq_match_window #(
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic             bit_in,
    input  logic             overlap,
    input  logic [3:0]       len,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);

    logic [PAT_W-1:0] win_q, win_d;
    logic [3:0]       fill_q, fill_d;
    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] win_shifted;
    logic             full_after;

    // Only the low len bits take part in the compare.
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
        assign mask[gi] = (4'(gi) < len);
    end

    assign win_shifted = {win_q[PAT_W-2:0], bit_in};
    assign full_after  = ({1'b0, fill_q} + 5'd1) >= {1'b0, len};
    assign hit         = shift && full_after
                         && ((win_shifted & mask) == (pattern & mask));

    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        if (clear) begin
            win_d  = '0;
            fill_d = 4'd0;
        end else if (shift) begin
            win_d  = win_shifted;
            fill_d = (fill_q >= len) ? len : fill_q + 4'd1;
            if (hit && !overlap) begin
                fill_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q  <= '0;
            fill_q <= 4'd0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Controller for the serial sequence detector path.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   cfg_pattern/len/overlap/target   : run configuration, latched on start
//   start, abort                     : arm request / stop request
//   data_valid, data_in              : qualified serial bit stream
//   busy                             : high while in RUN
//   match                            : one-cycle pulse per detected pattern
//   match_count                      : saturating match count of current/last run
//   done, timeout                    : one-cycle end-of-run pulses
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int PAT_W    = DEF_PAT_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int MAX_BITS = DEF_MAX_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [3:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             data_valid,
    input  logic             data_in,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             done,
    output logic             timeout
);

    localparam int BC_W = $clog2(MAX_BITS + 1);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pattern_q;
    logic [3:0]       len_q;
    logic             overlap_q;
    logic [CNT_W-1:0] target_q;
    logic [BC_W-1:0]  bit_count_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             match_q, done_q, timeout_q;

    logic arm, accept, hit, target_hit, last_bit;

    seq_match_window #(.PAT_W(PAT_W)) u_window (
        .clk     (clk),
        .rst     (rst),
        .clear   (arm),
        .shift   (accept),
        .bit_in  (data_in),
        .overlap (overlap_q),
        .len     (len_q),
        .pattern (pattern_q),
        .hit     (hit)
    );

    // Saturating increment on a hit.
    assign count_d    = (hit && count_q != '1) ? count_q + CNT_W'(1) : count_q;
    assign target_hit = hit && (target_q != '0) && (count_d == target_q);
    assign last_bit   = accept && (bit_count_q == BC_W'(MAX_BITS - 1));

    always_comb begin
        state_d = state_q;
        arm     = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    arm     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // A bit arriving alongside abort is dropped.
                accept = data_valid && !abort;
                if (abort || target_hit || last_bit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pattern_q   <= '0;
            len_q       <= 4'd1;
            overlap_q   <= 1'b0;
            target_q    <= '0;
            bit_count_q <= '0;
            count_q     <= '0;
            match_q     <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            match_q   <= hit;
            done_q    <= target_hit;
            // done takes precedence when the last budgeted bit hits target.
            timeout_q <= last_bit && !target_hit;
            if (arm) begin
                pattern_q   <= cfg_pattern;
                len_q       <= clamp_len(cfg_len, PAT_W);
                overlap_q   <= cfg_overlap;
                target_q    <= cfg_target;
                bit_count_q <= '0;
                count_q     <= '0;
            end else if (accept) begin
                bit_count_q <= bit_count_q + BC_W'(1);
                count_q     <= count_d;
            end
        end
    end

    assign busy        = (state_q == RUN);
    assign match       = match_q;
    assign match_count = count_q;
    assign done        = done_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic [7:0] cfg_target;
    logic       start, abort, data_valid, data_in;
    logic       busy, match, done, timeout;
    logic [7:0] match_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.PAT_W(8), .CNT_W(8), .MAX_BITS(100)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .start       (start),
        .abort       (abort),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .busy        (busy),
        .match       (match),
        .match_count (match_count),
        .done        (done),
        .timeout     (timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [7:0] p, input logic [3:0] l,
                       input logic o, input logic [7:0] t);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_target  = t;
        start       = 1'b1;
        step();
        start       = 1'b0;
        // Scramble cfg to show it is latched only at start.
        cfg_pattern = ~p;
        cfg_len     = 4'd3;
        cfg_overlap = ~o;
        cfg_target  = 8'd7;
    endtask

    task automatic send(input logic b);
        data_valid = 1'b1;
        data_in    = b;
        step();
        data_valid = 1'b0;
        data_in    = 1'b0;
        $display("bit=%b match=%b count=%0d busy=%b done=%b timeout=%b",
                 b, match, match_count, busy, done, timeout);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({busy, match, match_count, done, timeout} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b match=%b count=%0d done=%b timeout=%b exp all 0",
                     busy, match, match_count, done, timeout);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_overlap();
        logic s  [7] = '{1, 0, 1, 1, 0, 1, 1};
        logic em [7] = '{0, 0, 0, 1, 0, 0, 1};
        int   ec [7] = '{0, 0, 0, 1, 1, 1, 2};
        arm(8'b1011, 4'd4, 1'b1, 8'd3);
        checks++;
        if (busy !== 1'b1 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL overlap_arm got busy=%b count=%0d exp busy=1 count=0", busy, match_count);
        end
        for (int i = 0; i < 7; i++) begin
            send(s[i]);
            checks++;
            if (match !== em[i] || match_count !== 8'(ec[i])) begin
                errors++;
                $display("FAIL overlap_bit%0d got match=%b count=%0d exp match=%b count=%0d",
                         i + 1, match, match_count, em[i], ec[i]);
            end
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL overlap_end got busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        do_abort();
    endtask

    task automatic test_no_overlap();
        logic s  [10] = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
        logic em [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        int   ec [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 2};
        arm(8'b1011, 4'd4, 1'b0, 8'd3);
        for (int i = 0; i < 10; i++) begin
            send(s[i]);
            checks++;
            if (match !== em[i] || match_count !== 8'(ec[i])) begin
                errors++;
                $display("FAIL nooverlap_bit%0d got match=%b count=%0d exp match=%b count=%0d",
                         i + 1, match, match_count, em[i], ec[i]);
            end
        end
        do_abort();
    endtask

    task automatic test_done();
        logic em [5] = '{0, 1, 1, 0, 0};
        logic ed [5] = '{0, 0, 1, 0, 0};
        logic eb [5] = '{1, 1, 0, 0, 0};
        int   ec [5] = '{0, 1, 2, 2, 2};
        arm(8'b11, 4'd2, 1'b1, 8'd2);
        for (int i = 0; i < 5; i++) begin
            send(1'b1);
            checks++;
            if (match !== em[i] || done !== ed[i] || busy !== eb[i]
                || match_count !== 8'(ec[i]) || timeout !== 1'b0) begin
                errors++;
                $display("FAIL done_bit%0d got m=%b d=%b b=%b t=%b c=%0d exp m=%b d=%b b=%b t=0 c=%0d",
                         i + 1, match, done, busy, timeout, match_count, em[i], ed[i], eb[i], ec[i]);
            end
        end
    endtask

    task automatic test_timeout();
        arm(8'b1011, 4'd4, 1'b1, 8'd0);
        for (int i = 1; i <= 100; i++) begin
            send(1'b0);
            if (i == 99) begin
                checks++;
                if (timeout !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_bit99 got t=%b b=%b exp t=0 b=1", timeout, busy);
                end
            end
        end
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL timeout_bit100 got t=%b b=%b d=%b c=%0d exp t=1 b=0 d=0 c=0",
                     timeout, busy, done, match_count);
        end
        step();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse got t=%b exp t=0", timeout);
        end
    endtask

    task automatic test_timeout_gaps();
        arm(8'b1011, 4'd4, 1'b1, 8'd0);
        for (int i = 1; i <= 100; i++) begin
            send(1'b0);
            if (i % 10 == 9) begin
                step();
                step();
                step();
                checks++;
                if (timeout !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL gaps_after_bit%0d got t=%b b=%b exp t=0 b=1", i, timeout, busy);
                end
            end
        end
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL gaps_bit100 got t=%b b=%b exp t=1 b=0", timeout, busy);
        end
    endtask

    task automatic test_last_bit(input logic [7:0] tgt, input logic exp_done,
                                 input logic exp_to);
        arm(8'b1, 4'd1, 1'b1, tgt);
        for (int i = 1; i < 100; i++) send(1'b0);
        send(1'b1);
        checks++;
        if (match !== 1'b1 || done !== exp_done || timeout !== exp_to || busy !== 1'b0) begin
            errors++;
            $display("FAIL lastbit_tgt%0d got m=%b d=%b t=%b b=%b exp m=1 d=%b t=%b b=0",
                     tgt, match, done, timeout, busy, exp_done, exp_to);
        end
    endtask

    task automatic test_abort();
        arm(8'b11, 4'd2, 1'b1, 8'd3);
        send(1'b1);
        send(1'b1);
        send(1'b0);
        send(1'b1);
        checks++;
        if (match_count !== 8'd1) begin
            errors++;
            $display("FAIL abort_pre got c=%0d exp c=1", match_count);
        end
        abort      = 1'b1;
        data_valid = 1'b1;
        data_in    = 1'b1;
        step();
        abort      = 1'b0;
        data_valid = 1'b0;
        data_in    = 1'b0;
        checks++;
        if (match !== 1'b0 || done !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0
            || match_count !== 8'd1) begin
            errors++;
            $display("FAIL abort_cycle got m=%b d=%b t=%b b=%b c=%0d exp m=0 d=0 t=0 b=0 c=1",
                     match, done, timeout, busy, match_count);
        end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || match_count !== 8'd1) begin
            errors++;
            $display("FAIL abort_start_idle got b=%b c=%0d exp b=0 c=1", busy, match_count);
        end
        arm(8'b11, 4'd2, 1'b1, 8'd3);
        checks++;
        if (busy !== 1'b1 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL abort_rearm got b=%b c=%0d exp b=1 c=0", busy, match_count);
        end
        do_abort();
    endtask

    task automatic test_rst_midrun();
        arm(8'b11, 4'd2, 1'b1, 8'd5);
        send(1'b1);
        rst        = 1'b1;
        data_valid = 1'b1;
        data_in    = 1'b1;
        step();
        rst        = 1'b0;
        data_valid = 1'b0;
        data_in    = 1'b0;
        checks++;
        if ({busy, match, match_count, done, timeout} !== 12'd0) begin
            errors++;
            $display("FAIL rst_midrun got b=%b m=%b c=%0d d=%b t=%b exp all 0",
                     busy, match, match_count, done, timeout);
        end
        send(1'b1);
        checks++;
        if (busy !== 1'b0 || match !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore got b=%b m=%b exp b=0 m=0", busy, match);
        end
    endtask

    task automatic test_len0();
        logic s  [5] = '{1, 0, 1, 1, 0};
        int   ec [5] = '{1, 1, 2, 3, 3};
        arm(8'b0000_0001, 4'd0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) begin
            send(s[i]);
            checks++;
            if (match !== s[i] || match_count !== 8'(ec[i])) begin
                errors++;
                $display("FAIL len0_bit%0d got m=%b c=%0d exp m=%b c=%0d",
                         i + 1, match, match_count, s[i], ec[i]);
            end
        end
        do_abort();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; data_valid = 1'b0; data_in = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_target = '0;
        test_reset();
        test_overlap();
        test_no_overlap();
        test_done();
        test_timeout();
        test_timeout_gaps();
        test_last_bit(8'd1, 1'b1, 1'b0);
        test_last_bit(8'd2, 1'b0, 1'b1);
        test_abort();
        test_rst_midrun();
        test_len0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Controller and sequencer for the serial bit-stream sequence detector path.
- Software loads a programmable pattern (1..PAT_W bits), overlap mode, target match count and a bit budget, then arms the block.
- The block samples qualified serial bits, reports each match and counts matches.
- It finishes with done when the target count is reached, or with timeout when the bit budget is exhausted; it sits between the config/CSR layer and the raw serial input.

Parameters:
- PAT_W, 8, maximum pattern length in bits
- CNT_W, 8, width of target and match counter
- MAX_BITS, 100, bit budget per run; reaching it without hitting target raises timeout

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- cfg_pattern  in  PAT_W  pattern; bit [len-1] is the first bit received, bit 0 the last
- cfg_len  in  4  pattern length; 0 treated as 1, values >PAT_W treated as PAT_W
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = window cleared after a match
- cfg_target  in  CNT_W  matches required for done; 0 = never done (run to timeout/abort)
- start  in  1  arm request, honoured only in IDLE
- abort  in  1  stop the run, return to IDLE
- data_valid  in  1  qualifies data_in this cycle
- data_in  in  1  serial data bit
- busy  out  1  high while in RUN
- match  out  1  one-cycle pulse per detected pattern
- match_count  out  CNT_W  matches in the current/last run, saturating
- done  out  1  one-cycle pulse, target reached
- timeout  out  1  one-cycle pulse, budget exhausted

Behaviour:
- Reset (rst=1 at a rising edge):
  - State returns to IDLE.
  - All outputs are 0: busy, match, match_count, done, timeout.
  - Window, fill counter and bit counter are cleared.
  - Reset overrides all other inputs, including mid-run.
- States:
  - IDLE -> RUN on start=1 and abort=0. On that edge: latch cfg_* (cfg inputs are ignored thereafter until the next start), clear match_count, window, fill and bit_count.
  - RUN: each edge with data_valid=1 accepts a bit. The bit shifts into the window LSB, fill saturates at the effective length, and bit_count increments.
  - RUN -> IDLE on done, timeout or abort.
- Match rule:
  - The accepted bit completes a match if fill (including this bit) >= len and window[len-1:0] (including this bit) == pattern[len-1:0].
  - match is registered: high in the cycle after the sampling edge, for exactly one cycle.
  - match_count increments at the same edge and saturates at 2^CNT_W-1.
  - With overlap=0, fill is cleared to 0 after a match; with overlap=1, fill is untouched.
- done:
  - Asserted at the same edge as the match that brings match_count to target (target != 0).
  - busy drops at that same edge.
- timeout:
  - Asserted at the edge accepting bit number MAX_BITS if done is not raised at that edge.
  - If the final bit also completes the target match, done wins and timeout stays 0.
  - A match on the final bit without reaching target still pulses match together with timeout.
- abort:
  - In RUN, the next state is IDLE and no done/timeout is raised.
  - A bit presented in the abort cycle is discarded.
  - abort has priority over start in IDLE; abort in IDLE is a no-op.
- Other rules:
  - start during RUN is ignored.
  - data_valid=0 cycles hold all state; bits are ignored in IDLE.
  - match_count holds its final value in IDLE until the next start.
- Throughput: one bit per cycle, with no bubbles required.

Decomposition:
- Package seq_detect_pkg:
  - state enum (IDLE, RUN)
  - default PAT_W/CNT_W/MAX_BITS constants
  - function clamping cfg_len to 1..PAT_W
- Sub-module seq_match_window:
  - shift register, fill counter, masked compare
  - inputs: shift, clear, len, pattern
  - output: hit, combinational on the incoming bit
- Top-level seq_detect_ctrl holds the FSM, bit/match counters and output registers.

Test Plan:
- pattern=4'b1011, len=4, overlap=1, target=3; stream 1,0,1,1,0,1,1 -> match pulses after bits 4 and 7 (1-based), match_count=2, busy still 1, no done.
- Same stream with overlap=0 -> single match after bit 4, match_count=1; a further 0,1,1 -> second match after bit 10.
- target=2, pattern=2'b11, len=2, overlap=1; stream 1,1,1 -> matches after bits 2 and 3; done with the second match; busy=0; later bits ignored, match_count stays 2.
- target=0, 100 bits of all zeros with pattern 1011 -> timeout pulse after bit 100, match_count=0, no done; with data_valid gaps inserted, timeout comes only after 100 valid bits.
- Abort at bit 5 mid-run, same cycle as data_valid=1 -> no match/done/timeout; next start clears match_count to 0. start and abort together in IDLE -> stays IDLE.
- rst asserted mid-run with match pending -> all outputs 0 next cycle; cfg_len=0 run with pattern bit0=1 -> every accepted 1 produces a match.
